cru_bus_decoder: RTL

// - Upstream of the CRU bit consumers (SAMS mapper, DSR paging). Sees raw TMS9900 CRU traffic (CRUCLK, A3-A14, CRUOUT).
// - CRUCLK is asynchronous to clk. The block synchronises it, glitch-filters it and edge-detects it.
// - Decodes peripheral CRU space >1000->1FFF and holds each card's bit 0 (card select) plus SAMS bit 1 (transparent).
// - Emits one-cycle write strobes for every other card bit, and returns CRUIN for TB/STCR.

---
 rtl/cru_pkg.sv | 15 +
 rtl/cru_pulse_filter.sv | 86 ++++++++
 rtl/cru_bus_decoder.sv | 85 ++++++++
 3 files changed

// File: rtl/cru_pkg.sv
// rtl/cru_pkg.sv - shared CRU decode constants, FSM state type and address helpers
package cru_pkg;

    localparam logic [1:0] CRU_PERIPH_PREFIX = 2'b01;
    localparam logic [3:0] CARD_SAMS         = 4'hE;
    localparam logic [3:0] CARD_RS232        = 4'h3;
    localparam logic [3:0] CARD_FDC          = 4'h1;

    typedef enum logic [1:0] {IDLE, QUAL, ISSUE, WAITLO} cru_state_t;

    function automatic logic in_periph(input logic [12:0] address);
        return address[12:11] == CRU_PERIPH_PREFIX;
    endfunction

endpackage

// File: rtl/cru_pulse_filter.sv
// rtl/cru_pulse_filter.sv - CRUCLK synchroniser, glitch filter and one-shot write_fire generator
module cru_pulse_filter
    import cru_pkg::*;
#(
    parameter int FILTER_CYCLES = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        cruclk,
    input  logic        memen,
    input  logic [12:0] cru_address,
    input  logic        cruout,
    output logic        write_fire,
    output logic [12:0] write_address,
    output logic        write_data
);

    logic       sync1, sync2;
    logic [1:0] fill;
    logic [2:0] count, count_next;
    logic [3:0] count_inc;
    logic       latch;
    cru_state_t state, state_next;

    assign count_inc = {1'b0, count} + 4'd1;

    // Reset parks in WAITLO; it only falls through to IDLE once the synchroniser has
    // refilled and shows cruclk low, so a pulse spanning reset never issues a write.
    always_ff @(posedge clk) begin
        if (reset) begin
            sync1         <= 1'b0;
            sync2         <= 1'b0;
            fill          <= 2'd0;
            state         <= WAITLO;
            count         <= 3'd0;
            write_address <= 13'd0;
            write_data    <= 1'b0;
        end else begin
            sync1 <= cruclk;
            sync2 <= sync1;
            if (fill != 2'd2) fill <= fill + 2'd1;
            state <= state_next;
            count <= count_next;
            if (latch) begin
                write_address <= cru_address;
                write_data    <= cruout;
            end
        end
    end

    always_comb begin
        state_next = state;
        count_next = count;
        latch      = 1'b0;
        write_fire = 1'b0;
        case (state)
            IDLE: begin
                if (sync2 && memen) begin
                    state_next = QUAL;
                    count_next = 3'd1;
                end
            end
            QUAL: begin
                if (!sync2 || !memen) begin
                    state_next = IDLE;
                    count_next = 3'd0;
                end else if (count_inc >= FILTER_CYCLES[3:0]) begin
                    state_next = ISSUE;
                    count_next = 3'd0;
                    latch      = 1'b1;
                end else begin
                    count_next = count_inc[2:0];
                end
            end
            ISSUE: begin
                write_fire = 1'b1;
                state_next = WAITLO;
            end
            WAITLO: begin
                if (!sync2 && fill == 2'd2) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

endmodule

// File: rtl/cru_bus_decoder.sv
// rtl/cru_bus_decoder.sv - peripheral CRU decode, card-select/SAMS registers, write strobes and CRUIN readback
module cru_bus_decoder
    import cru_pkg::*;
#(
    parameter int FILTER_CYCLES = 2,
    parameter bit EXCLUSIVE_SEL = 1'b1,
    parameter int SAMS_CARD     = 14
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        cruclk,
    input  logic        memen,
    input  logic [12:0] cru_address,
    input  logic        cruout,
    input  logic        cruin_ext,
    output logic        cruin,
    output logic [15:0] cru_cardsel,
    output logic        sams_transparent,
    output logic        bit_wr_strobe,
    output logic [3:0]  bit_wr_card,
    output logic [6:0]  bit_wr_index,
    output logic        bit_wr_data
);

    logic        write_fire;
    logic [12:0] write_address;
    logic        write_data;
    logic [3:0]  w_card, r_card;
    logic [6:0]  w_index, r_index;
    logic        read_bit;

    cru_pulse_filter #(.FILTER_CYCLES(FILTER_CYCLES)) u_filter (
        .clk           (clk),
        .reset         (reset),
        .cruclk        (cruclk),
        .memen         (memen),
        .cru_address   (cru_address),
        .cruout        (cruout),
        .write_fire    (write_fire),
        .write_address (write_address),
        .write_data    (write_data)
    );

    assign w_card  = write_address[10:7];
    assign w_index = write_address[6:0];
    assign r_card  = cru_address[10:7];
    assign r_index = cru_address[6:0];

    always_ff @(posedge clk) begin
        if (reset) begin
            cru_cardsel      <= 16'h0000;
            sams_transparent <= 1'b0;
            bit_wr_strobe    <= 1'b0;
            bit_wr_card      <= 4'd0;
            bit_wr_index     <= 7'd0;
            bit_wr_data      <= 1'b0;
            cruin            <= 1'b0;
        end else begin
            bit_wr_strobe <= 1'b0;
            cruin         <= read_bit;
            if (write_fire && in_periph(write_address)) begin
                if (w_index == 7'd0) begin
                    if (EXCLUSIVE_SEL && write_data) cru_cardsel <= 16'h0001 << w_card;
                    else cru_cardsel[w_card] <= write_data;
                end else begin
                    if (w_card == SAMS_CARD[3:0] && w_index == 7'd1) sams_transparent <= write_data;
                    bit_wr_strobe <= 1'b1;
                    bit_wr_card   <= w_card;
                    bit_wr_index  <= w_index;
                    bit_wr_data   <= write_data;
                end
            end
        end
    end

    always_comb begin
        read_bit = 1'b0;
        if (in_periph(cru_address)) begin
            if (r_index == 7'd0) read_bit = cru_cardsel[r_card];
            else if (r_card == SAMS_CARD[3:0] && r_index == 7'd1) read_bit = sams_transparent;
            else read_bit = cruin_ext;
        end
    end

endmodule
